// File: rtl/dmac_multi_channel.sv
// Multi-channel device-to-memory DMA engine: per-channel descriptors, round-robin channel pick, BR/BG bus handshake.
// Optional build macro DMAC_CYCLE_STEAL_EN: release the bus after every word instead of bursting a whole descriptor.
module dmac_multi_channel #(
  parameter  int WORD_SIZE = 16,
  parameter  int NUM_CH    = 4,
  parameter  int LEN_W     = 8,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CH_W-1:0]      cmd_ch,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  output logic                 BR,
  input  logic                 BG,
  output logic                 use_bus,
  output logic                 writeMem,
  output logic [WORD_SIZE-1:0] address2Wr,
  output logic [CH_W-1:0]      dev_ch,
  input  logic [WORD_SIZE-1:0] dev_data,
  output logic [WORD_SIZE-1:0] data_out,
  output logic [NUM_CH-1:0]    interrupt,
  input  logic [NUM_CH-1:0]    int_ack
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_REL} state_t;

  state_t                             state;
  logic [NUM_CH-1:0]                  busy;
  logic [NUM_CH-1:0][WORD_SIZE-1:0]   ch_addr;
  logic [NUM_CH-1:0][LEN_W-1:0]       ch_len;
  logic [CH_W-1:0]                    cur, rr_ptr, pick, pick_nxt;
  logic [CH_W:0]                      sum;
  logic                               pick_vld, wr, accept;
  logic [NUM_CH-1:0]                  int_set;

  assign cmd_ready  = (int'(cmd_ch) < NUM_CH) && !busy[cmd_ch];
  assign accept     = cmd_valid && cmd_ready;
  // Bus drive follows BG combinationally so a lost grant silences the write in the same cycle.
  assign wr         = (state == S_XFER) && BG;
  assign use_bus    = wr;
  assign writeMem   = wr;
  assign address2Wr = wr ? ch_addr[cur] : '0;
  assign data_out   = wr ? dev_data : '0;
  assign dev_ch     = cur;

  // Lowest offset from rr_ptr wins, so scan from the far end and let nearer hits overwrite.
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    sum      = '0;
    for (int o = NUM_CH - 1; o >= 0; o--) begin
      sum = {1'b0, rr_ptr} + (CH_W+1)'(o);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      if (busy[sum[CH_W-1:0]]) begin
        pick     = sum[CH_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_nxt = (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;

  always_comb begin
    int_set = '0;
    if (accept && cmd_len == '0) int_set[cmd_ch] = 1'b1;
    if (state == S_REL && ch_len[cur] == '0) int_set[cur] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      BR        <= 1'b0;
      busy      <= '0;
      ch_addr   <= '0;
      ch_len    <= '0;
      cur       <= '0;
      rr_ptr    <= '0;
      interrupt <= '0;
    end else begin
      interrupt <= (interrupt & ~int_ack) | int_set;
      // Only idle channels accept, and the engine only touches the busy one, so these never collide.
      if (accept) begin
        ch_addr[cmd_ch] <= cmd_addr;
        ch_len[cmd_ch]  <= cmd_len;
        busy[cmd_ch]    <= (cmd_len != '0);
      end
      case (state)
        S_IDLE: if (pick_vld) begin
          cur    <= pick;
          rr_ptr <= pick_nxt;
          BR     <= 1'b1;
          state  <= S_REQ;
        end
        S_REQ: if (BG) state <= S_XFER;
        S_XFER: if (BG) begin
          ch_addr[cur] <= ch_addr[cur] + 1'b1;
          ch_len[cur]  <= ch_len[cur] - 1'b1;
`ifdef DMAC_CYCLE_STEAL_EN
          state <= S_REL;
`else
          if (ch_len[cur] == LEN_W'(1)) state <= S_REL;
`endif
        end
        S_REL: begin
          BR <= 1'b0;
          if (ch_len[cur] == '0) busy[cur] <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmac_multi_channel.sv
// Scoreboard bench for dmac_multi_channel: stimulus queues expected writes, a negedge monitor pops and compares.
module tb_dmac_multi_channel;
  localparam int WS = 16, NC = 4, LW = 8, CW = 2;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [CW-1:0] cmd_ch = '0;
  logic [WS-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          BR, BG, use_bus, writeMem, bg_allow = 1'b0;
  logic [WS-1:0] address2Wr, data_out, dev_data;
  logic [CW-1:0] dev_ch;
  logic [NC-1:0] interrupt, int_ack = '0;

  typedef struct packed { logic [WS-1:0] addr; logic [WS-1:0] data; } wr_t;
  wr_t exp_q[$];
  int  tests = 0, fails = 0, wr_count = 0, br_rises = 0;
  logic br_q = 1'b0;

  function automatic logic [WS-1:0] dat(int ch);
    return 16'hC000 + 16'(ch * 273);
  endfunction

  always #5 clk = ~clk;
  assign BG       = BR & bg_allow;
  assign dev_data = dat(int'(dev_ch));

  dmac_multi_channel #(.WORD_SIZE(WS), .NUM_CH(NC), .LEN_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .BR(BR), .BG(BG),
    .use_bus(use_bus), .writeMem(writeMem), .address2Wr(address2Wr), .dev_ch(dev_ch),
    .dev_data(dev_data), .data_out(data_out), .interrupt(interrupt), .int_ack(int_ack));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every bus write must match the head of the expected queue.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (reset_n) begin
      if (BR && !br_q) br_rises++;
      br_q = BR;
      if (writeMem) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: addr %h data %h with empty queue", address2Wr, data_out);
        end else begin
          e = exp_q.pop_front();
          check("write", {address2Wr, data_out}, {e.addr, e.data});
        end
        wr_count++;
      end
    end else br_q = 1'b0;
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(int ch, logic [WS-1:0] a, int len);
    for (int i = 0; i < len; i++) exp_q.push_back('{addr: a + 16'(i), data: dat(ch)});
  endtask

  task automatic issue(int ch, logic [WS-1:0] a, logic [LW-1:0] len);
    cmd_valid = 1'b1; cmd_ch = CW'(ch); cmd_addr = a; cmd_len = len;
    #1 check("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_int(logic [NC-1:0] mask, int budget, string name);
    int n = 0;
    while ((interrupt & mask) !== mask && n < budget) begin tick(); n++; end
    check(name, interrupt & mask, mask);
  endtask

  task automatic ack(logic [NC-1:0] m);
    int_ack = m; tick(); int_ack = '0;
  endtask

  initial begin
    int n, base;
    tick(2);
    check("rst_br", BR, 0);          check("rst_use_bus", use_bus, 0);
    check("rst_writemem", writeMem, 0); check("rst_int", interrupt, 0);
    check("rst_cmd_ready", cmd_ready, 1); check("rst_addr", address2Wr, 0);
    check("rst_data", data_out, 0);  check("rst_dev_ch", dev_ch, 0);
    reset_n = 1'b1; tick();

    // Single burst on ch0
    bg_allow = 1'b1;
    push(0, 16'h0010, 12); issue(0, 16'h0010, 12);
    n = 0; while (!writeMem && n < 20) begin tick(); n++; end
    n = 0; while (writeMem && n < 20) begin tick(); n++; end
`ifdef DMAC_CYCLE_STEAL_EN
    check("t2_run_len", n, 1);
`else
    check("t2_run_len", n, 12);
`endif
    wait_int(4'b0001, 80, "t2_int");
    check("t2_br_low", BR, 0); check("t2_int_val", interrupt, 4'b0001);
    check("t2_q_empty", exp_q.size(), 0);
    ack(4'b0001); check("t2_ack", interrupt, 0);

    // Grant loss after word 2 on ch1
    base = wr_count;
    push(1, 16'h0100, 5); issue(1, 16'h0100, 5);
    n = 0; while (wr_count < base + 2 && n < 40) begin tick(); n++; end
    check("t3_two_words", wr_count - base, 2);
    bg_allow = 1'b0; #1;
    repeat (3) begin
      check("t3_no_write", writeMem, 0);
`ifndef DMAC_CYCLE_STEAL_EN
      check("t3_br_held", BR, 1);
`endif
      tick();
    end
    bg_allow = 1'b1;
    wait_int(4'b0010, 60, "t3_int");
    check("t3_int_val", interrupt, 4'b0010);
    ack(4'b0010); tick(3);
    check("t3_int_once", interrupt, 0);
    check("t3_q_empty", exp_q.size(), 0);

    // Reset mid-burst with a sticky interrupt pending
    issue(3, 16'h0000, 0);
    base = wr_count;
    push(0, 16'h0300, 20); issue(0, 16'h0300, 20);
    n = 0; while (wr_count < base + 3 && n < 40) begin tick(); n++; end
    reset_n = 1'b0; #1;
    check("t1_br", BR, 0); check("t1_use_bus", use_bus, 0);
    check("t1_writemem", writeMem, 0); check("t1_int", interrupt, 0);
    check("t1_cmd_ready", cmd_ready, 1);
    exp_q.delete();
    tick(2); reset_n = 1'b1; tick(4);
    check("t1_discarded", BR, 0);

    // Round robin: ch0/ch2/ch3 queued before the grant opens
    bg_allow = 1'b0; br_rises = 0;
`ifdef DMAC_CYCLE_STEAL_EN
    for (int w = 0; w < 2; w++) begin
      exp_q.push_back('{addr: 16'h0400 + 16'(w), data: dat(0)});
      exp_q.push_back('{addr: 16'h0420 + 16'(w), data: dat(2)});
      exp_q.push_back('{addr: 16'h0430 + 16'(w), data: dat(3)});
    end
`else
    push(0, 16'h0400, 2); push(2, 16'h0420, 2); push(3, 16'h0430, 2);
`endif
    issue(0, 16'h0400, 2); issue(2, 16'h0420, 2); issue(3, 16'h0430, 2);
    bg_allow = 1'b1;
    wait_int(4'b1101, 100, "t4_int");
`ifdef DMAC_CYCLE_STEAL_EN
    check("t4_br_pulses", br_rises, 6);
`else
    check("t4_br_pulses", br_rises, 3);
`endif
    check("t4_q_empty", exp_q.size(), 0);
    ack(4'b1101);

    // Address wrap, zero length, ack/set collision
    push(2, 16'hFFFE, 4); issue(2, 16'hFFFE, 4);
    wait_int(4'b0100, 60, "t5_wrap_int");
    check("t5_q_empty", exp_q.size(), 0);
    ack(4'b0100);
    br_rises = 0;
    issue(3, 16'h1234, 0);
    check("t5_zero_int", interrupt, 4'b1000);
    tick(3);
    check("t5_zero_no_br", br_rises, 0); check("t5_zero_br", BR, 0);
    ack(4'b1000);
    int_ack = 4'b0010; issue(1, 16'h2000, 0); int_ack = '0;
    check("t5_set_ack_collide", interrupt, 4'b0010);
    ack(4'b0010); check("t5_ack_clear", interrupt, 0);

    // len=3: one BR pulse in burst mode, one per word in cycle-steal mode
    br_rises = 0;
    push(0, 16'h0500, 3); issue(0, 16'h0500, 3);
    wait_int(4'b0001, 60, "t6_int");
`ifdef DMAC_CYCLE_STEAL_EN
    check("t6_br_pulses", br_rises, 3);
`else
    check("t6_br_pulses", br_rises, 1);
`endif
    check("t6_int_val", interrupt, 4'b0001);
    check("final_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
